// File: rtl/systolic_pe_array_if.sv
// +----------------------------------------------------------------------+
// | Module      : systolic_pe_array_if                                   |
// | Description : Operand feed, run control and readout bus for the      |
// |               4x4 systolic PE array.                                 |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

interface systolic_pe_array_if #(
   parameter int WIDTH = 32
);
   // run control
   logic             start;
   logic             busy;
   logic             done;

   // skewed operands from the A (rows) and B (columns) feeders
   logic [WIDTH-1:0] a_in0;
   logic [WIDTH-1:0] a_in1;
   logic [WIDTH-1:0] a_in2;
   logic [WIDTH-1:0] a_in3;
   logic [WIDTH-1:0] b_in0;
   logic [WIDTH-1:0] b_in1;
   logic [WIDTH-1:0] b_in2;
   logic [WIDTH-1:0] b_in3;

   // random-access result readout
   logic             rd_en;
   logic [3:0]       rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;

   // feeder / host side
   modport master (
      output start,
      output a_in0, a_in1, a_in2, a_in3,
      output b_in0, b_in1, b_in2, b_in3,
      output rd_en, rd_addr,
      input  busy, done,
      input  rd_data, rd_valid
   );

   // array side
   modport slave (
      input  start,
      input  a_in0, a_in1, a_in2, a_in3,
      input  b_in0, b_in1, b_in2, b_in3,
      input  rd_en, rd_addr,
      output busy, done,
      output rd_data, rd_valid
   );
endinterface

`default_nettype wire

// File: rtl/systolic_pe_array.sv
// +----------------------------------------------------------------------+
// | Module      : systolic_pe_array                                      |
// | Description : 4x4 output-stationary systolic array of MAC PEs.       |
// |               Operands arrive pre-skewed from the A/B feeders, flow  |
// |               right (A) and down (B) through pipe registers, and     |
// |               each PE accumulates one element of C = A x B. A small  |
// |               sequencer times fill/drain, pulses done, then the 16   |
// |               results can be read back one per cycle.                |
// | Options     : PE_ARRAY_SAT_EN - saturating accumulation using the    |
// |               full-width product instead of wrapping accumulation.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module systolic_pe_array #(
   parameter int WIDTH = 32,
   parameter int K_LEN = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   systolic_pe_array_if.slave     pe_bus
);

   localparam int N     = 4;
   // counter must reach K_LEN+7, the last cycle in which PE(3,3) accumulates
   localparam int CNT_W = $clog2(K_LEN + 8);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN + 7);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;
   logic              done_q;

   logic [WIDTH-1:0]  a_in  [N];
   logic [WIDTH-1:0]  b_in  [N];
   logic [WIDTH-1:0]  a_q   [N][N];
   logic [WIDTH-1:0]  b_q   [N][N];
   logic [WIDTH-1:0]  acc_q [N][N];
   logic [WIDTH-1:0]  acc_d [N][N];

   logic              acc_clr;
   logic              acc_en;

   logic [WIDTH-1:0]  rd_data_q;
   logic              rd_valid_q;
   logic [1:0]        rd_row;
   logic [1:0]        rd_col;

   assign a_in[0] = pe_bus.a_in0;
   assign a_in[1] = pe_bus.a_in1;
   assign a_in[2] = pe_bus.a_in2;
   assign a_in[3] = pe_bus.a_in3;
   assign b_in[0] = pe_bus.b_in0;
   assign b_in[1] = pe_bus.b_in1;
   assign b_in[2] = pe_bus.b_in2;
   assign b_in[3] = pe_bus.b_in3;

   // A new run wipes the previous results on the same edge it is accepted;
   // start while a run is in progress is simply ignored.
   assign acc_clr = (state_q == IDLE) && pe_bus.start;
   assign acc_en  = (state_q == RUN);

   // Run sequencer: counts fill/drain latency and produces busy/done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pe_bus.start) begin
                  state_q <= RUN;
                  cnt_q   <= CNT_W'(1);
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Operand pipes: A moves right along each row, B moves down each column.
   // They shift unconditionally; idle feeders push zeros through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_q[i][j] <= '0;
               b_q[i][j] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            a_q[i][0] <= a_in[i];
            b_q[0][i] <= b_in[i];
            for (int j = 1; j < N; j++) begin
               a_q[i][j] <= a_q[i][j-1];
               b_q[j][i] <= b_q[j-1][i];
            end
         end
      end
   end

   // Per-PE next accumulator value from the operands currently at that PE.
   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
`ifdef PE_ARRAY_SAT_EN
         localparam logic signed [2*WIDTH:0] SAT_MAX =
            {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
         localparam logic signed [2*WIDTH:0] SAT_MIN =
            {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

         logic signed [2*WIDTH-1:0] prod;
         logic signed [2*WIDTH:0]   sum;

         // sign-extend both operands so the 2W-bit product is the true signed product
         assign prod = $signed({{WIDTH{a_q[gi][gj][WIDTH-1]}}, a_q[gi][gj]})
                     * $signed({{WIDTH{b_q[gi][gj][WIDTH-1]}}, b_q[gi][gj]});
         // one extra bit so acc + product can never overflow before clamping
         assign sum  = {{(WIDTH+1){acc_q[gi][gj][WIDTH-1]}}, acc_q[gi][gj]}
                     + {prod[2*WIDTH-1], prod};
         assign acc_d[gi][gj] = (sum > SAT_MAX) ? SAT_MAX[WIDTH-1:0] :
                                (sum < SAT_MIN) ? SAT_MIN[WIDTH-1:0] :
                                                  sum[WIDTH-1:0];
`else
         // the low WIDTH bits of a signed product equal those of the unsigned one
         logic [WIDTH-1:0] prod_lo;

         assign prod_lo       = a_q[gi][gj] * b_q[gi][gj];
         assign acc_d[gi][gj] = acc_q[gi][gj] + prod_lo;
`endif
      end
   end

   // Accumulators: clear on run start, accumulate while running, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               acc_q[i][j] <= '0;
            end
         end
      end else if (acc_clr) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               acc_q[i][j] <= '0;
            end
         end
      end else if (acc_en) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               acc_q[i][j] <= acc_d[i][j];
            end
         end
      end
   end

   assign rd_row = pe_bus.rd_addr[3:2];
   assign rd_col = pe_bus.rd_addr[1:0];

   // Readout port: one-cycle latency; reads during a run return invalid zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else if (pe_bus.rd_en) begin
         if (busy_q) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_data_q  <= acc_q[rd_row][rd_col];
            rd_valid_q <= 1'b1;
         end
      end else begin
         rd_valid_q <= 1'b0;
      end
   end

   assign pe_bus.busy     = busy_q;
   assign pe_bus.done     = done_q;
   assign pe_bus.rd_data  = rd_data_q;
   assign pe_bus.rd_valid = rd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_pe_array.sv
// +----------------------------------------------------------------------+
// | Module      : tb_systolic_pe_array                                   |
// | Description : Scoreboard bench for systolic_pe_array. A reference    |
// |               model computes C = A x B with plain arithmetic; reads  |
// |               push expected responses that a monitor checks.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_systolic_pe_array;

   localparam int WIDTH = 32;
   localparam int K     = 4;

   typedef logic [31:0] word_t;
   typedef struct packed {
      logic  v;
      word_t d;
   } rsp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   systolic_pe_array_if #(.WIDTH(WIDTH)) bus ();

   systolic_pe_array #(
      .WIDTH (WIDTH),
      .K_LEN (K)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pe_bus (bus)
   );

   int    checks   = 0;
   int    failures = 0;
   rsp_t  sb[$];
   word_t A [2][4][K];
   word_t B [2][K][4];
   word_t model_C [16];

   task automatic check(input string name, input word_t act, input word_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result for element (i,j) of run r, accumulated in k order.
   function automatic word_t model_elem(input int r, input int i, input int j);
      longint acc;
      longint p;
      acc = 0;
      for (int k = 0; k < K; k++) begin
         p = longint'($signed(A[r][i][k])) * longint'($signed(B[r][k][j]));
         acc = acc + p;
`ifdef PE_ARRAY_SAT_EN
         if (acc > 64'sd2147483647) acc = 64'sd2147483647;
         else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`endif
      end
      return word_t'(acc);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input word_t av[4], input word_t bv[4]);
      bus.a_in0 = av[0]; bus.a_in1 = av[1]; bus.a_in2 = av[2]; bus.a_in3 = av[3];
      bus.b_in0 = bv[0]; bus.b_in1 = bv[1]; bus.b_in2 = bv[2]; bus.b_in3 = bv[3];
   endtask

   task automatic idle_inputs();
      word_t z[4];
      for (int i = 0; i < 4; i++) z[i] = '0;
      set_ops(z, z);
      bus.start   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.rd_addr = 4'd0;
   endtask

   // Drive `total` cycles starting at cycle 0. Start pulses at st0/st1, reads of
   // address 3 at rd0/rd1 (-1 = unused). Busy/done are checked every cycle from
   // the accepted-run list; operands come from A/B of each accepted run.
   task automatic exec(input int total, input int st0, input int st1,
                       input int rd0, input int rd1);
      int    starts[$];
      bit    busy_e, done_e, st;
      int    k, last;
      word_t av[4], bv[4];
      word_t cur;
      for (int c = 0; c < total; c++) begin
         busy_e = 1'b0;
         done_e = 1'b0;
         foreach (starts[r]) begin
            if (c >= starts[r] + 1 && c <= starts[r] + K + 7) busy_e = 1'b1;
            if (c == starts[r] + K + 8) done_e = 1'b1;
         end
         check("busy", word_t'(bus.busy), word_t'(busy_e));
         check("done", word_t'(bus.done), word_t'(done_e));
         st = (c == st0) || (c == st1);
         if (st && !busy_e && starts.size() < 2) starts.push_back(c);
         for (int i = 0; i < 4; i++) begin
            av[i] = '0;
            bv[i] = '0;
            foreach (starts[r]) begin
               k = c - starts[r] - i - 1;
               if (k >= 0 && k < K) begin
                  av[i] = A[r][i][k];
                  bv[i] = B[r][k][i];
               end
            end
         end
         set_ops(av, bv);
         bus.start = st;
         if (c == rd0 || c == rd1) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = 4'd3;
            if (busy_e) begin
               sb.push_back('{1'b0, 32'h0});
            end else begin
               last = -1;
               foreach (starts[r]) if (starts[r] + K + 8 <= c) last = r;
               cur = (last < 0) ? model_C[3] : model_elem(last, 0, 3);
               sb.push_back('{1'b1, cur});
            end
         end else begin
            bus.rd_en = 1'b0;
         end
         step();
      end
      idle_inputs();
      foreach (starts[r]) begin
         if (starts[r] + K + 8 < total)
            for (int e = 0; e < 16; e++) model_C[e] = model_elem(r, e / 4, e % 4);
      end
   endtask

   task automatic read_all();
      for (int a = 0; a < 16; a++) begin
         bus.rd_en   = 1'b1;
         bus.rd_addr = 4'(a);
         sb.push_back('{1'b1, model_C[a]});
         step();
      end
      bus.rd_en = 1'b0;
      step();
      step();
      check("sb_drain", word_t'(sb.size()), 32'd0);
   endtask

   // Monitor: one cycle after each read request, pop and compare; otherwise
   // rd_valid must be low and rd_data must hold.
   initial begin
      logic  pend;
      word_t last_d;
      rsp_t  e;
      pend   = 1'b0;
      last_d = '0;
      forever begin
         @(posedge clk);
         pend = rst_n && bus.rd_en;
         @(negedge clk);
         if (!rst_n) begin
            last_d = '0;
         end else if (pend) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underflow actual=response required=none at %0t", $time);
            end else begin
               e = sb.pop_front();
               check("rd_valid", word_t'(bus.rd_valid), word_t'(e.v));
               check("rd_data", bus.rd_data, e.d);
            end
            last_d = bus.rd_data;
         end else begin
            check("rd_valid_idle", word_t'(bus.rd_valid), 32'd0);
            check("rd_data_hold", bus.rd_data, last_d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      for (int e = 0; e < 16; e++) model_C[e] = '0;
      rst_n = 1'b0;
      step(); step(); step();
      rst_n = 1'b1;
      step();
      check("reset_busy", word_t'(bus.busy), 32'd0);
      check("reset_done", word_t'(bus.done), 32'd0);
      check("reset_rd_valid", word_t'(bus.rd_valid), 32'd0);
      check("reset_rd_data", bus.rd_data, 32'd0);
      read_all();

      // all ones: every result is K
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < K; k++) begin A[0][i][k] = 32'd1; B[0][k][i] = 32'd1; end
      exec(13, 0, -1, -1, -1);
      check("ones_c00", model_C[0], 32'd4);
      read_all();

      // A row i = i+1, B = 2
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < K; k++) begin A[0][i][k] = word_t'(i + 1); B[0][k][i] = 32'd2; end
      exec(13, 0, -1, -1, -1);
      read_all();

      // A = identity, B[k][j] = 4k+j: C must equal B (start clears old sums)
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < K; k++) begin
            A[0][i][k] = (i == k) ? 32'd1 : 32'd0;
            B[0][k][i] = word_t'(k * 4 + i);
         end
      exec(13, 0, -1, -1, -1);
      read_all();

      // positive overflow
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < K; k++) begin A[0][i][k] = 32'h0001_0000; B[0][k][i] = 32'h0001_0000; end
      exec(13, 0, -1, -1, -1);
      read_all();

      // negative overflow
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < K; k++) begin A[0][i][k] = 32'hFFFF_0000; B[0][k][i] = 32'h0001_0000; end
      exec(13, 0, -1, -1, -1);
      read_all();

      // random operands, ignored start in cycle 5, read while busy and in done cycle
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < K; k++) begin A[0][i][k] = $urandom(); B[0][k][i] = $urandom(); end
      exec(13, 0, 5, 3, 12);
      read_all();

      // start in the done cycle chains a second run (small signed randoms)
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 4; i++)
            for (int k = 0; k < K; k++) begin
               A[r][i][k] = word_t'($signed(10'($urandom_range(0, 1023))));
               B[r][k][i] = word_t'($signed(10'($urandom_range(0, 1023))));
            end
      exec(25, 0, 12, -1, -1);
      read_all();

      // reset in the middle of a run
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < K; k++) begin A[0][i][k] = $urandom(); B[0][k][i] = $urandom(); end
      exec(6, 0, -1, -1, -1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", word_t'(bus.busy), 32'd0);
      check("midrst_done", word_t'(bus.done), 32'd0);
      check("midrst_rd_valid", word_t'(bus.rd_valid), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int e = 0; e < 16; e++) model_C[e] = '0;
      step();
      exec(14, -1, -1, -1, -1);
      read_all();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/systolic_pe_array.md
Name: systolic_pe_array

Overview:
- 4x4 output-stationary systolic array of multiply-accumulate PEs.
- Sits directly downstream of the skewed operand feeders:
  - the A feeder drives row inputs a_in0..a_in3 (row i delayed i cycles, zero when idle);
  - the B feeder drives column inputs b_in0..b_in3 with the same skew.
- Each PE accumulates one element of C = A x B.
- An internal sequencer counts the fill/drain latency, flags done, then allows random-access readout of the 16 results.

Parameters:
- WIDTH, 32: operand, accumulator and readout data width in bits.
- K_LEN, 4: inner dimension, i.e. products per PE per run. Legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse, asserted in the same cycle as the feeders' read enable. Begins a run.
- a_in0..a_in3  in  WIDTH each  row operands, from the A feeder.
- b_in0..b_in3  in  WIDTH each  column operands, from the B feeder.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse; all 16 accumulators are final.
- rd_en  in  1  readout request.
- rd_addr  in  4  result index = row*4 + col.
- rd_data  out  WIDTH  selected accumulator.
- rd_valid  out  1  rd_data valid this cycle.

Behaviour:
- Reset values: all accumulators, operand pipe registers and cycle counter 0; busy=0, done=0, rd_data=0, rd_valid=0. Reset mid-run aborts immediately with no pending done.
- Cycle numbering: the start cycle is cycle 0. Operand element k of row i appears on a_in_i in cycle k+i+1. Column j follows the same rule on b_in_j.
- Operand pipes (shift every cycle, regardless of busy):
  - a_reg(i,0) <= a_in_i; a_reg(i,j) <= a_reg(i,j-1).
  - b_reg(0,j) <= b_in_j; b_reg(i,j) <= b_reg(i-1,j).
- Arithmetic:
  - product = signed WIDTH x WIDTH -> 2*WIDTH.
  - Default: acc <= acc + product[WIDTH-1:0], wrapping modulo 2^WIDTH.
- FSM with states IDLE, RUN:
  - IDLE, start=1 -> RUN: clears all 16 accumulators on that edge; busy=1 from cycle 1; counter loads 1.
  - RUN: acc(i,j) updates every cycle from a_reg(i,j), b_reg(i,j). Zeros from the idle feeders contribute nothing. Counter increments.
  - RUN, counter == K_LEN+7 -> IDLE: busy=0 and done=1 in cycle K_LEN+8, which is cycle 12 for K_LEN=4. done lasts exactly one cycle.
  - In IDLE, accumulators hold.
- Simultaneous/boundary events:
  - start while busy: ignored.
  - start in the done cycle: accepted as a new run. Accumulators clear; done still pulses.
- Readout:
  - rd_en=1 and busy=0: next cycle rd_data = acc[rd_addr], rd_valid=1. Latency 1; back-to-back reads allowed, one per cycle.
  - rd_en=1 and busy=1: next cycle rd_valid=0, rd_data=0.
  - rd_en=0: rd_valid=0 next cycle; rd_data holds its last value.

Optional Feature:
- Macro PE_ARRAY_SAT_EN.
- Defined: each accumulate computes acc + the full 2*WIDTH signed product at 2*WIDTH+1 bits, then clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before writing back.
- Undefined: wrapping truncated accumulation as above.
- Timing and ports are identical either way.

Test Plan:
- Reset then idle: rst_n low mid-run -> busy=0, done=0, rd_valid=0; reads after reset return 0 for all 16 addresses.
- A all 1, B all 1, K_LEN=4, start at cycle 0 -> busy cycles 1..11, done pulse only in cycle 12; rd_addr 0..15 each return 4, rd_valid one cycle after each rd_en.
- A row i = i+1 (all k), B all 2 -> rd_addr r*4+c returns 8*(r+1): 8, 16, 24, 32 per row. Then a second run with A=I, B[k][j]=k*4+j -> C equals B exactly, confirming the start-time clear.
- Overflow, a=0x00010000, b=0x00010000 on all inputs, K_LEN=4 -> each result 0x00000000 without PE_ARRAY_SAT_EN; 0x7FFFFFFF with it. Negative case a=0xFFFF0000, b=0x00010000 with SAT -> 0x80000000.
- start pulse in cycle 5 of a run -> ignored; done still at cycle 12; results unchanged. start in the done cycle -> new run, next done at cycle 24.
- rd_en during busy, addr 3 -> rd_valid=0, rd_data=0 next cycle. rd_en in the done cycle -> valid data next cycle.
